// File: rtl/ps2_mouse_tracker_pkg.sv
// Shared constants for the PS/2 mouse tracker: status-bit positions, FSM states, packet length.
// PS2_WHEEL_EN selects 4-byte IntelliMouse packets instead of the default 3-byte packets.
package ps2_pkg;

   localparam int B_L    = 0;
   localparam int B_R    = 1;
   localparam int B_M    = 2;
   localparam int B_SYNC = 3;
   localparam int B_XS   = 4;
   localparam int B_YS   = 5;
   localparam int B_XO   = 6;
   localparam int B_YO   = 7;

`ifdef PS2_WHEEL_EN
   localparam int PKT_LEN = 4;
`else
   localparam int PKT_LEN = 3;
`endif

   typedef enum logic [2:0] {
      WAIT_B0,
      WAIT_B1,
      WAIT_B2,
`ifdef PS2_WHEEL_EN
      WAIT_B3,
`endif
      UPDATE
   } state_t;

endpackage

// File: rtl/ps2_mouse_tracker_axis_accum.sv
// One cursor axis: sensitivity shift, optional negation, clamped registered position.
module ps2_axis_accum #(
   parameter int W     = 10,
   parameter int LIMIT = 640,
   parameter int SHIFT = 0,
   parameter bit NEG   = 1'b0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              apply,
   input  logic signed [8:0] delta,
   output logic [W-1:0]      pos
);

   // Two guard bits keep pos + step from wrapping before the clamp.
   localparam int SW = ((W > 9) ? W : 9) + 2;
   localparam logic signed [SW-1:0] MAXV = SW'(LIMIT - 1);

   logic signed [8:0]    d_s;
   logic signed [SW-1:0] step;
   logic signed [SW-1:0] sum;
   logic [W-1:0]         pos_next;

   always_comb begin
      d_s  = delta >>> SHIFT;
      step = {{(SW-9){d_s[8]}}, d_s};
      if (NEG) step = -step;
      sum  = $signed({{(SW-W){1'b0}}, pos}) + step;
      pos_next = sum[W-1:0];
      if (sum < 0)
         pos_next = '0;
      else if (sum > MAXV)
         pos_next = W'(LIMIT - 1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         pos <= W'(LIMIT / 2);
      else if (apply)
         pos <= pos_next;
   end

endmodule

// File: rtl/ps2_mouse_tracker.sv
// Aligns PS/2 mouse bytes into packets and tracks clamped cursor, buttons and framing errors.
// Define PS2_WHEEL_EN for 4-byte IntelliMouse packets and the wheel accumulator output.
module ps2_mouse_tracker
   import ps2_pkg::*;
#(
   parameter int SCREEN_W       = 640,
   parameter int SCREEN_H       = 480,
   parameter int X_W            = 10,
   parameter int Y_W            = 9,
   parameter int DELTA_SHIFT    = 0,
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           enable,
   input  logic [7:0]     rx_data,
   input  logic           rx_valid,
   output logic [X_W-1:0] pos_x,
   output logic [Y_W-1:0] pos_y,
   output logic [2:0]     buttons,
   output logic           pkt_valid,
`ifdef PS2_WHEEL_EN
   output logic [7:0]     wheel,
`endif
   output logic [7:0]     sync_err_cnt
);

   localparam int IW = $clog2(TIMEOUT_CYCLES + 1);

   state_t            state;
   logic [7:0]        b0, b1, b2;
`ifdef PS2_WHEEL_EN
   logic [3:0]        wdelta;
`endif
   logic [IW-1:0]     idle_cnt;
   logic              apply;
   logic signed [8:0] dx, dy;

   // A packet is dropped if enable falls during its UPDATE cycle.
   assign apply = (state == UPDATE) && enable;
   assign dx    = b0[B_XO] ? 9'sd0 : $signed({b0[B_XS], b1});
   assign dy    = b0[B_YO] ? 9'sd0 : $signed({b0[B_YS], b2});

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= WAIT_B0;
         b0           <= '0;
         b1           <= '0;
         b2           <= '0;
`ifdef PS2_WHEEL_EN
         wdelta       <= '0;
         wheel        <= '0;
`endif
         idle_cnt     <= '0;
         buttons      <= '0;
         pkt_valid    <= 1'b0;
         sync_err_cnt <= '0;
      end else begin
         pkt_valid <= apply;
         if (apply) begin
            buttons <= b0[B_M:B_L];
`ifdef PS2_WHEEL_EN
            wheel   <= wheel + {{4{wdelta[3]}}, wdelta};
`endif
         end
         if (!enable) begin
            state    <= WAIT_B0;
            idle_cnt <= '0;
         end else begin
            case (state)
               // UPDATE treats a same-cycle byte as byte 0 of the next packet.
               WAIT_B0, UPDATE: begin
                  state <= WAIT_B0;
                  if (rx_valid) begin
                     if (rx_data[B_SYNC]) begin
                        b0       <= rx_data;
                        state    <= WAIT_B1;
                        idle_cnt <= '0;
                     end else if (sync_err_cnt != 8'hFF) begin
                        sync_err_cnt <= sync_err_cnt + 8'd1;
                     end
                  end
               end
               default: begin
                  if (rx_valid) begin
                     idle_cnt <= '0;
                     case (state)
                        WAIT_B1: begin
                           b1    <= rx_data;
                           state <= WAIT_B2;
                        end
`ifdef PS2_WHEEL_EN
                        WAIT_B2: begin
                           b2    <= rx_data;
                           state <= WAIT_B3;
                        end
                        default: begin
                           wdelta <= rx_data[3:0];
                           state  <= UPDATE;
                        end
`else
                        default: begin
                           b2    <= rx_data;
                           state <= UPDATE;
                        end
`endif
                     endcase
                  end else if (idle_cnt == IW'(TIMEOUT_CYCLES - 1)) begin
                     state    <= WAIT_B0;
                     idle_cnt <= '0;
                     if (sync_err_cnt != 8'hFF)
                        sync_err_cnt <= sync_err_cnt + 8'd1;
                  end else begin
                     idle_cnt <= idle_cnt + IW'(1);
                  end
               end
            endcase
         end
      end
   end

   ps2_axis_accum #(.W(X_W), .LIMIT(SCREEN_W), .SHIFT(DELTA_SHIFT), .NEG(1'b0)) u_x (
      .clk   (clk),
      .rst   (rst),
      .apply (apply),
      .delta (dx),
      .pos   (pos_x)
   );

   // PS/2 +Y is up while screen Y grows downward.
   ps2_axis_accum #(.W(Y_W), .LIMIT(SCREEN_H), .SHIFT(DELTA_SHIFT), .NEG(1'b1)) u_y (
      .clk   (clk),
      .rst   (rst),
      .apply (apply),
      .delta (dy),
      .pos   (pos_y)
   );

endmodule

// File: tb/tb_ps2_mouse_tracker.sv
// Directed and randomized bench for ps2_mouse_tracker against a byte-level packet model.
module tb_ps2_mouse_tracker;

   localparam int SW = 640;
   localparam int SH = 480;
   localparam int DS = 0;
   localparam int TO = 40;
`ifdef PS2_WHEEL_EN
   localparam int PL = 4;
`else
   localparam int PL = 3;
`endif

   logic       clk = 1'b0;
   logic       rst, enable, rx_valid;
   logic [7:0] rx_data;
   logic [9:0] pos_x;
   logic [8:0] pos_y;
   logic [2:0] buttons;
   logic       pkt_valid;
   logic [7:0] sync_err_cnt;
`ifdef PS2_WHEEL_EN
   logic [7:0] wheel;
`endif

   ps2_mouse_tracker #(
      .SCREEN_W(SW), .SCREEN_H(SH), .X_W(10), .Y_W(9),
      .DELTA_SHIFT(DS), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk), .rst(rst), .enable(enable), .rx_data(rx_data), .rx_valid(rx_valid),
      .pos_x(pos_x), .pos_y(pos_y), .buttons(buttons), .pkt_valid(pkt_valid),
`ifdef PS2_WHEEL_EN
      .wheel(wheel),
`endif
      .sync_err_cnt(sync_err_cnt)
   );

   always #5 clk = ~clk;

   int pulses = 0;
   always @(posedge clk) if (pkt_valid) pulses <= pulses + 1;

   int n_chk = 0;
   int n_err = 0;

   // Reference model state
   int mx, my, mbtn, merr, mwheel, mpkts, pidx;
   logic [7:0] pk [4];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic int clampi(input int v, input int hi);
      if (v < 0) return 0;
      if (v > hi) return hi;
      return v;
   endfunction

   task automatic mreset();
      mx = SW / 2; my = SH / 2; mbtn = 0; merr = 0; mwheel = 0; pidx = 0;
   endtask

   task automatic mapply();
      int dx, dy, w;
      dx = pk[0][4] ? int'(pk[1]) - 256 : int'(pk[1]);
      dy = pk[0][5] ? int'(pk[2]) - 256 : int'(pk[2]);
      if (pk[0][6]) dx = 0;
      if (pk[0][7]) dy = 0;
      dx = dx >>> DS;
      dy = dy >>> DS;
      mx = clampi(mx + dx, SW - 1);
      my = clampi(my - dy, SH - 1);
      mbtn = int'(pk[0][2:0]);
      if (PL == 4) begin
         w = pk[3][3] ? int'(pk[3][3:0]) - 16 : int'(pk[3][3:0]);
         mwheel = (mwheel + w) & 255;
      end
      mpkts++;
   endtask

   task automatic mbyte(input logic [7:0] b);
      if (pidx == 0) begin
         if (b[3]) begin pk[0] = b; pidx = 1; end
         else if (merr < 255) merr++;
      end else begin
         pk[pidx] = b;
         pidx++;
         if (pidx == PL) begin mapply(); pidx = 0; end
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_data = b; rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
      mbyte(b);
   endtask

   task automatic chk_state(input string tag);
      chk({tag, "_x"}, 32'(pos_x), mx);
      chk({tag, "_y"}, 32'(pos_y), my);
      chk({tag, "_btn"}, 32'(buttons), mbtn);
      chk({tag, "_err"}, 32'(sync_err_cnt), merr);
      chk({tag, "_pulses"}, pulses, mpkts);
`ifdef PS2_WHEEL_EN
      chk({tag, "_wheel"}, 32'(wheel), mwheel);
`endif
   endtask

   // Sends an aligned packet and checks the single pkt_valid pulse two cycles after the last strobe.
   task automatic send_pkt(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] c, input logic [7:0] d);
      send_byte(a); send_byte(b); send_byte(c);
      if (PL == 4) send_byte(d);
      chk({tag, "_pv_n1"}, 32'(pkt_valid), 0);
      @(negedge clk);
      chk({tag, "_pv_n2"}, 32'(pkt_valid), 1);
      @(negedge clk);
      chk({tag, "_pv_n3"}, 32'(pkt_valid), 0);
      chk_state(tag);
   endtask

   task automatic pulse_rst(input string tag);
      rst = 1'b1;
      #1;
      chk({tag, "_x"}, 32'(pos_x), SW / 2);
      chk({tag, "_y"}, 32'(pos_y), SH / 2);
      chk({tag, "_btn"}, 32'(buttons), 0);
      chk({tag, "_err"}, 32'(sync_err_cnt), 0);
      chk({tag, "_pv"}, 32'(pkt_valid), 0);
`ifdef PS2_WHEEL_EN
      chk({tag, "_wheel"}, 32'(wheel), 0);
`endif
      @(negedge clk);
      rst = 1'b0;
      mreset();
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1; enable = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
      mreset(); mpkts = 0;
      repeat (3) @(negedge clk);
      chk("rst_x", 32'(pos_x), 320);
      chk("rst_y", 32'(pos_y), 240);
      chk("rst_btn", 32'(buttons), 0);
      chk("rst_err", 32'(sync_err_cnt), 0);
      chk("rst_pv", 32'(pkt_valid), 0);
      rst = 1'b0; enable = 1'b1;
      @(negedge clk);

      send_pkt("basic", 8'h09, 8'h05, 8'h03, 8'h00);
      chk("basic_x_const", 32'(pos_x), 325);
      chk("basic_y_const", 32'(pos_y), 237);
      chk("basic_btn_const", 32'(buttons), 1);

      send_byte(8'h00);
      send_pkt("resync", 8'h08, 8'h00, 8'h00, 8'h00);
      chk("resync_err_const", 32'(sync_err_cnt), 1);
      chk("resync_x_const", 32'(pos_x), 325);

      // enable low drops the partial packet without counting an error
      send_byte(8'h08); send_byte(8'h05);
      enable = 1'b0; @(negedge clk); enable = 1'b1; pidx = 0;
      send_pkt("enable", 8'h08, 8'h01, 8'h00, 8'h00);
      chk("enable_x_const", 32'(pos_x), 326);

      pulse_rst("rst2");
      for (int i = 0; i < 3; i++) send_pkt("clamp_lo", 8'h38, 8'h80, 8'h80, 8'h00);
      chk("clamp_lo_x", 32'(pos_x), 0);
      for (int i = 0; i < 6; i++) send_pkt("clamp_hi", 8'h08, 8'h7F, 8'h00, 8'h00);
      chk("clamp_hi_x", 32'(pos_x), 639);
      chk("clamp_hi_y", 32'(pos_y), 479);
      send_pkt("ovf", 8'hD8, 8'h80, 8'h80, 8'h00);
      chk("ovf_x", 32'(pos_x), 639);

      pulse_rst("rst3");
      send_byte(8'h08); send_byte(8'h05);
      repeat (TO + 5) @(negedge clk);
      if (pidx != 0) begin merr++; pidx = 0; end
      chk("timeout_err", 32'(sync_err_cnt), 1);
      chk("timeout_pulses", pulses, mpkts);
      send_pkt("after_to", 8'h08, 8'h01, 8'h00, 8'h00);
      chk("after_to_x", 32'(pos_x), 321);

      // next packet's byte 0 lands in the UPDATE cycle
      send_byte(8'h09); send_byte(8'h02); send_byte(8'h00);
      if (PL == 4) send_byte(8'h00);
      send_pkt("b2b", 8'h0A, 8'h03, 8'h01, 8'h00);

`ifdef PS2_WHEEL_EN
      pulse_rst("rst4");
      send_pkt("wheel", 8'h08, 8'h00, 8'h00, 8'h0F);
      chk("wheel_ff", 32'(wheel), 32'hFF);
      send_byte(8'h08); send_byte(8'h00);
      pulse_rst("rst_mid");
      send_pkt("wheel2", 8'h08, 8'h00, 8'h00, 8'h03);
      chk("wheel2_val", 32'(wheel), 3);
`endif

      for (int i = 0; i < 150; i++) begin
         logic [7:0] r0;
         repeat ($urandom_range(0, 2)) @(negedge clk);
         if ($urandom_range(0, 4) == 0) send_byte(8'($urandom) & 8'hF7);
         r0 = 8'($urandom) | 8'h08;
         send_pkt("rand", r0, 8'($urandom), 8'($urandom), 8'($urandom));
      end

      for (int i = 0; i < 260; i++) send_byte(8'h00);
      @(negedge clk);
      chk("sat_err", 32'(sync_err_cnt), 255);
      chk_state("final");

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
